// File: rtl/vga_pkg.sv
// Purpose: shared 1280x1024@60 raster constants and types for the VGA path and the renderer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package vga_pkg;

    // Horizontal timing, in pixel clocks
    localparam int H_VISIBLE = 1280;
    localparam int H_FRONT   = 48;
    localparam int H_SYNC    = 112;
    localparam int H_BACK    = 248;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    // Vertical timing, in lines
    localparam int V_VISIBLE = 1024;
    localparam int V_FRONT   = 1;
    localparam int V_SYNC    = 3;
    localparam int V_BACK    = 38;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [7:0]         colour_t;
    typedef logic [3:0]         dac_t;

    // Raw raster controls carried down the delay line alongside the renderer pipeline
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } raster_ctl_t;

    // DAC only has 4 bits: keep the MSB nibble, no rounding
    function automatic dac_t colour_msb(input colour_t c);
        return dac_t'(c >> 4);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Purpose: DEPTH-stage shift register with a parameterised reset value.
// Latency: DEPTH clocks from din to dout.
// Backpressure: none; shifts every clock.
// Ports: clk, rst_n (async active-low), din/dout WIDTH bits.
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RST_VAL;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose: free-running raster counters, sync/blank decode and registered VGA DAC output stage.
// Latency: coordinates/strobes 0 clocks; VGA_* pins PIPE_DELAY+1 clocks after the coordinate.
// Backpressure: none; free-running every pixel clock.
// Ports: pixelClock, resetN (async active-low); redValue/greenValue/blueValue 8-bit renderer colour;
//        XPixelPosition/YPixelPosition, frameStart, lineStart; VGA_R/G/B, VGA_HS, VGA_VS, displayEnable.
module vga_timing_gen #(
    parameter int   H_VISIBLE  = vga_pkg::H_VISIBLE,
    parameter int   H_FRONT    = vga_pkg::H_FRONT,
    parameter int   H_SYNC     = vga_pkg::H_SYNC,
    parameter int   H_BACK     = vga_pkg::H_BACK,
    parameter int   V_VISIBLE  = vga_pkg::V_VISIBLE,
    parameter int   V_FRONT    = vga_pkg::V_FRONT,
    parameter int   V_SYNC     = vga_pkg::V_SYNC,
    parameter int   V_BACK     = vga_pkg::V_BACK,
    parameter logic H_POL      = 1'b1,
    parameter logic V_POL      = 1'b1,
    parameter int   PIPE_DELAY = 1
) (
    input  logic        pixelClock,
    input  logic        resetN,
    input  logic [7:0]  redValue,
    input  logic [7:0]  greenValue,
    input  logic [7:0]  blueValue,
    output logic [10:0] XPixelPosition,
    output logic [10:0] YPixelPosition,
    output logic        frameStart,
    output logic        lineStart,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        displayEnable
);
    import vga_pkg::*;

    localparam int LINE_CLKS   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int FRAME_LINES = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (LINE_CLKS > 2048) begin : g_line_too_long
        $fatal(1, "vga_timing_gen: horizontal total exceeds 2048");
    end
    if (FRAME_LINES > 2048) begin : g_frame_too_tall
        $fatal(1, "vga_timing_gen: vertical total exceeds 2048");
    end
    if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_bad_pipe_delay
        $fatal(1, "vga_timing_gen: PIPE_DELAY must be 1..4");
    end

    localparam coord_t H_LAST     = coord_t'(LINE_CLKS - 1);
    localparam coord_t V_LAST     = coord_t'(FRAME_LINES - 1);
    localparam coord_t H_VIS_END  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_END  = coord_t'(V_VISIBLE);
    localparam coord_t H_SYNC_BEG = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t H_SYNC_END = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_t V_SYNC_BEG = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t V_SYNC_END = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

    // Idle pattern of the raster controls: blank, both syncs at their inactive level
    localparam raster_ctl_t CTL_IDLE = '{de: 1'b0, hs: ~H_POL, vs: ~V_POL};

    coord_t      h_count;
    coord_t      v_count;
    raster_ctl_t ctl0;
    raster_ctl_t ctl_d;

    // Stage 0: raster counters; vertical advances only on the horizontal wrap
    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_count == H_LAST) begin
            h_count <= '0;
            v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
        end else begin
            h_count <= h_count + 1'b1;
        end
    end

    assign XPixelPosition = h_count;
    assign YPixelPosition = v_count;
    assign lineStart      = (h_count == '0);
    assign frameStart     = (h_count == '0) && (v_count == '0);

    // Raw decodes for the coordinate currently being issued
    always_comb begin
        ctl0    = CTL_IDLE;
        ctl0.de = (h_count < H_VIS_END) && (v_count < V_VIS_END);
        ctl0.hs = (h_count >= H_SYNC_BEG && h_count < H_SYNC_END) ? H_POL : ~H_POL;
        ctl0.vs = (v_count >= V_SYNC_BEG && v_count < V_SYNC_END) ? V_POL : ~V_POL;
    end

    // Hold the decodes back until the renderer's colour for the same pixel arrives
    vga_delay_line #(
        .WIDTH   ($bits(raster_ctl_t)),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (CTL_IDLE)
    ) u_ctl_delay (
        .clk   (pixelClock),
        .rst_n (resetN),
        .din   (ctl0),
        .dout  (ctl_d)
    );

    // Output register: colour blanked outside active video
    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            VGA_R         <= '0;
            VGA_G         <= '0;
            VGA_B         <= '0;
            VGA_HS        <= ~H_POL;
            VGA_VS        <= ~V_POL;
            displayEnable <= 1'b0;
        end else begin
            VGA_R         <= ctl_d.de ? colour_msb(redValue)   : '0;
            VGA_G         <= ctl_d.de ? colour_msb(greenValue) : '0;
            VGA_B         <= ctl_d.de ? colour_msb(blueValue)  : '0;
            VGA_HS        <= ctl_d.hs;
            VGA_VS        <= ctl_d.vs;
            displayEnable <= ctl_d.de;
        end
    end

endmodule
